// File: rtl/alu.sv
// 16-bit datapath ALU: combinational result with Zero/Carry, plus a registered
// copy of the flags for later conditional branches.
module alu (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] InputA,
    input  logic [15:0] InputB,
    input  logic [2:0]  OP,
    input  logic        FlagWe,
    output logic [15:0] Out,
    output logic        Zero,
    output logic        Carry,
    output logic        ZeroFlag,
    output logic        CarryFlag
);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_AND   = 3'b001;
    localparam logic [2:0] OP_OR    = 3'b010;
    localparam logic [2:0] OP_XOR   = 3'b011;
    localparam logic [2:0] OP_SHL   = 3'b100;
    localparam logic [2:0] OP_SHR   = 3'b101;
    localparam logic [2:0] OP_SUB   = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    // Bit 16 is the carry on add and the borrow on subtract.
    logic [16:0] sum;
    logic [16:0] diff;

    assign sum  = {1'b0, InputA} + {1'b0, InputB};
    assign diff = {1'b0, InputA} - {1'b0, InputB};

    always_comb begin
        Out   = 16'h0000;
        Carry = 1'b0;
        case (OP)
            OP_ADD: begin
                Out   = sum[15:0];
                Carry = sum[16];
            end
            OP_AND:   Out = InputA & InputB;
            OP_OR:    Out = InputA | InputB;
            OP_XOR:   Out = InputA ^ InputB;
            OP_SHL: begin
                Out   = {InputA[14:0], 1'b0};
                Carry = InputA[15];
            end
            OP_SHR: begin
                Out   = {1'b0, InputA[15:1]};
                Carry = InputA[0];
            end
            OP_SUB: begin
                Out   = diff[15:0];
                Carry = diff[16];
            end
            OP_PASSB: Out = InputB;
            default: begin
                Out   = 16'h0000;
                Carry = 1'b0;
            end
        endcase
    end

    assign Zero = ~|Out;

    // Reset wins over a simultaneous flag write.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ZeroFlag  <= 1'b0;
            CarryFlag <= 1'b0;
        end else if (FlagWe) begin
            ZeroFlag  <= Zero;
            CarryFlag <= Carry;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: combinational results per opcode, then the
// flag register's write, hold and reset-priority behaviour.
module tb_alu;

    logic        Clk;
    logic        Reset;
    logic [15:0] InputA;
    logic [15:0] InputB;
    logic [2:0]  OP;
    logic        FlagWe;
    logic [15:0] Out;
    logic        Zero;
    logic        Carry;
    logic        ZeroFlag;
    logic        CarryFlag;

    int checks = 0;
    int errors = 0;

    // Expected {ZeroFlag, CarryFlag} after each clock edge.
    logic [1:0] exp_q[$];

    alu dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .InputA    (InputA),
        .InputB    (InputB),
        .OP        (OP),
        .FlagWe    (FlagWe),
        .Out       (Out),
        .Zero      (Zero),
        .Carry     (Carry),
        .ZeroFlag  (ZeroFlag),
        .CarryFlag (CarryFlag)
    );

    // Clock and watchdog.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver tasks.
    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        InputA = a;
        InputB = b;
        OP     = op;
        #1;
    endtask

    // One rising edge, then sample on the falling edge against the queue head.
    task automatic clock_and_check_flags(input string tag);
        logic [1:0] exp;
        @(posedge Clk);
        @(negedge Clk);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: expected queue empty, got %b", tag, {ZeroFlag, CarryFlag});
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_zf"}, {15'h0, ZeroFlag}, {15'h0, exp[1]});
            check({tag, "_cf"}, {15'h0, CarryFlag}, {15'h0, exp[0]});
        end
    endtask

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic [15:0] out;
        logic        z;
        logic        c;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs[NVEC] = '{
        '{16'h0001, 16'h0001, 3'b001, 16'h0001, 1'b0, 1'b0},  // AND
        '{16'h0004, 16'h0001, 3'b101, 16'h0002, 1'b0, 1'b0},  // SHR
        '{16'h8001, 16'h0001, 3'b101, 16'h4000, 1'b0, 1'b1},  // SHR shifts out 1
        '{16'hFFFF, 16'h0001, 3'b000, 16'h0000, 1'b1, 1'b1},  // ADD wrap
        '{16'h0005, 16'h0005, 3'b110, 16'h0000, 1'b1, 1'b0},  // SUB equal
        '{16'h0003, 16'h0005, 3'b110, 16'hFFFE, 1'b0, 1'b1},  // SUB borrow
        '{16'h8001, 16'h0000, 3'b100, 16'h0002, 1'b0, 1'b1},  // SHL
        '{16'hA5A5, 16'hA5A5, 3'b011, 16'h0000, 1'b1, 1'b0},  // XOR self
        '{16'h5555, 16'h1234, 3'b111, 16'h1234, 1'b0, 1'b0},  // PASSB
        '{16'hF0F0, 16'h0F0F, 3'b010, 16'hFFFF, 1'b0, 1'b0},  // OR
        '{16'h1234, 16'h1111, 3'b000, 16'h2345, 1'b0, 1'b0}   // ADD no carry
    };

    initial begin
        Reset  = 1'b1;
        FlagWe = 1'b0;
        drive(16'h0000, 16'h0000, 3'b000);

        // Combinational vectors need no clock.
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].op);
            check($sformatf("v%0d_out", i), Out, vecs[i].out);
            check($sformatf("v%0d_zero", i), {15'h0, Zero}, {15'h0, vecs[i].z});
            check($sformatf("v%0d_carry", i), {15'h0, Carry}, {15'h0, vecs[i].c});
        end

        // Reset state of the flag register.
        exp_q.push_back(2'b00);
        clock_and_check_flags("reset");
        Reset = 1'b0;

        // ADD wrap sets both flags.
        drive(16'hFFFF, 16'h0001, 3'b000);
        FlagWe = 1'b1;
        exp_q.push_back(2'b11);
        clock_and_check_flags("we_add");

        // Flags hold while FlagWe is low and the inputs would give 0/0.
        FlagWe = 1'b0;
        drive(16'h0001, 16'h0001, 3'b001);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(2'b11);
            clock_and_check_flags($sformatf("hold%0d", i));
        end

        // Write a mixed pattern: SUB borrow gives Zero=0, Carry=1.
        drive(16'h0003, 16'h0005, 3'b110);
        FlagWe = 1'b1;
        exp_q.push_back(2'b01);
        clock_and_check_flags("we_sub");

        // Back to 1/1, then reset with FlagWe high must clear.
        drive(16'hFFFF, 16'h0001, 3'b000);
        exp_q.push_back(2'b11);
        clock_and_check_flags("we_add2");

        Reset = 1'b1;
        #1;
        check("rst_comb_out", Out, 16'h0000);
        check("rst_comb_carry", {15'h0, Carry}, 16'h0001);
        exp_q.push_back(2'b00);
        clock_and_check_flags("rst_prio");
        Reset  = 1'b0;
        FlagWe = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
